bsram_arbiter: RTL and testbench

BSRAM_ARBITER -- requirements
Module: bsram_arbiter

---
 rtl/bsram_arbiter.sv | 127 ++++++++++++
 tb/tb_bsram_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsram_arbiter.sv
// Two-port arbiter in front of a single-ported-per-direction BSRAM.
// Round-robin in IDLE, exclusive lock per port with a forced release after LOCK_MAX cycles.
module bsram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  mem_readEnable,
    output logic [ADDR_WIDTH-1:0] mem_readAddress,
    input  logic [DATA_WIDTH-1:0] mem_readData,
    output logic                  mem_writeEnable,
    output logic [ADDR_WIDTH-1:0] mem_writeAddress,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    output logic                  lock_timeout
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                state;
    state_t                lockTarget;
    logic                  rrPtr;
    logic [7:0]            lockCount;
    logic                  timeoutNow;
    logic                  grant0;
    logic                  grant1;
    logic                  anyGrant;
    logic                  selWrite;
    logic                  selLock;
    logic [ADDR_WIDTH-1:0] selAddress;
    logic [DATA_WIDTH-1:0] selWdata;

    // Grants are gated by reset so the combinational outputs also drop the instant reset asserts.
    always_comb begin
        timeoutNow = (state != IDLE) && (lockCount == 8'(LOCK_MAX));
        grant0     = 1'b0;
        grant1     = 1'b0;
        if (reset && !timeoutNow) begin
            case (state)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        grant0 = !rrPtr;
                        grant1 = rrPtr;
                    end else begin
                        grant0 = req0_valid;
                        grant1 = req1_valid;
                    end
                end
                LOCK0:   grant0 = req0_valid;
                LOCK1:   grant1 = req1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        anyGrant   = grant0 || grant1;
        selWrite   = grant0 ? req0_write   : req1_write;
        selLock    = grant0 ? req0_lock    : req1_lock;
        selAddress = grant0 ? req0_address : req1_address;
        selWdata   = grant0 ? req0_wdata   : req1_wdata;
        lockTarget = grant0 ? LOCK0 : LOCK1;

        mem_readEnable   = anyGrant && !selWrite;
        mem_readAddress  = mem_readEnable ? selAddress : '0;
        mem_writeEnable  = anyGrant && selWrite;
        mem_writeAddress = mem_writeEnable ? selAddress : '0;
        mem_writeData    = mem_writeEnable ? selWdata : '0;
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign lock_timeout = timeoutNow;

    // Response stage and arbitration state both advance on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rrPtr      <= 1'b0;
            lockCount  <= 8'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= grant0;
            rsp1_valid <= grant1;
            if (grant0 && !req0_write) rsp0_data <= mem_readData;
            if (grant1 && !req1_write) rsp1_data <= mem_readData;

            if (timeoutNow) begin
                state     <= IDLE;
                rrPtr     <= (state == LOCK0);
                lockCount <= 8'd0;
            end else begin
                if (state == IDLE && anyGrant) rrPtr <= grant0;
                if (anyGrant && selLock) begin
                    state     <= lockTarget;
                    lockCount <= (state == lockTarget) ? lockCount + 8'd1 : 8'd0;
                end else if (anyGrant && state != IDLE) begin
                    state     <= IDLE;
                    lockCount <= 8'd0;
                end else if (state != IDLE) begin
                    lockCount <= lockCount + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsram_arbiter.sv
// Directed bench for bsram_arbiter with a behavioural BSRAM model (same-cycle read, write on edge).
module tb_bsram_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0_valid, req0_write, req0_lock;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready, rsp0_valid;
    logic [DW-1:0] rsp0_data;
    logic          req1_valid, req1_write, req1_lock;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready, rsp1_valid;
    logic [DW-1:0] rsp1_data;
    logic          mem_readEnable, mem_writeEnable, lock_timeout;
    logic [AW-1:0] mem_readAddress, mem_writeAddress;
    logic [DW-1:0] mem_readData, mem_writeData;

    int testCount = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    bsram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_lock(req0_lock),
        .req0_address(req0_address), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_lock(req1_lock),
        .req1_address(req1_address), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress),
        .mem_readData(mem_readData), .mem_writeEnable(mem_writeEnable),
        .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData),
        .lock_timeout(lock_timeout)
    );

    // Unwritten words read back a fixed per-address pattern.
    logic [DW-1:0] memArray [256];
    bit            written  [256];

    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        return (a == 8'h05) ? 32'hDEADBEEF : {24'hC0FFEE, a};
    endfunction

    always @(posedge clock) begin
        if (mem_writeEnable) begin
            memArray[mem_writeAddress] <= mem_writeData;
            written[mem_writeAddress]  <= 1'b1;
        end
    end

    assign mem_readData = written[mem_readAddress] ? memArray[mem_readAddress] : initWord(mem_readAddress);

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic setReq0(input logic v, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = v; req0_write = w; req0_lock = l; req0_address = a; req0_wdata = d;
    endtask

    task automatic setReq1(input logic v, input logic w, input logic l, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = v; req1_write = w; req1_lock = l; req1_address = a; req1_wdata = d;
    endtask

    task automatic idleAll();
        setReq0(0, 0, 0, 8'h00, 32'h0);
        setReq1(0, 0, 0, 8'h00, 32'h0);
    endtask

    // Called 2 time units after a rising edge; returns at the same phase with reset released.
    task automatic doReset();
        reset = 1'b0;
        idleAll();
        @(posedge clock); #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        setReq0(1, 0, 0, 8'h07, 32'h0);
        setReq1(1, 0, 0, 8'h08, 32'h0);
        #12;
        checkVal("rst_ready0", req0_ready, 0);
        checkVal("rst_ready1", req1_ready, 0);
        checkVal("rst_rdEn", mem_readEnable, 0);
        checkVal("rst_rdAddr", mem_readAddress, 0);
        checkVal("rst_rspValid", {rsp0_valid, rsp1_valid}, 0);
        checkVal("rst_rspData0", rsp0_data, 0);
        checkVal("rst_timeout", lock_timeout, 0);

        // Single read, first grant right after reset release
        @(posedge clock); #2;
        reset = 1'b1;
        setReq0(1, 0, 0, 8'h05, 32'h0);
        setReq1(0, 0, 0, 8'h00, 32'h0);
        @(negedge clock);
        checkVal("rd_ready0", req0_ready, 1);
        checkVal("rd_ready1", req1_ready, 0);
        checkVal("rd_rdEn", mem_readEnable, 1);
        checkVal("rd_rdAddr", mem_readAddress, 8'h05);
        checkVal("rd_wrEn", mem_writeEnable, 0);
        @(posedge clock); #2;
        idleAll();
        @(negedge clock);
        checkVal("rd_rspValid", rsp0_valid, 1);
        checkVal("rd_rspData", rsp0_data, 32'hDEADBEEF);
        checkVal("rd_idleEn", mem_readEnable, 0);
        checkVal("rd_idleAddr", mem_readAddress, 0);
        @(posedge clock); #2;
        @(negedge clock);
        checkVal("rd_rspPulse", rsp0_valid, 0);

        // Contention: both ports read every cycle
        @(posedge clock); #2;
        doReset();
        for (int c = 0; c < 6; c++) begin
            setReq0(1, 0, 0, 8'(8'h20 + c), 32'h0);
            setReq1(1, 0, 0, 8'(8'h40 + c), 32'h0);
            @(negedge clock);
            checkVal($sformatf("rr_ready0_%0d", c), req0_ready, (c % 2) == 0);
            checkVal($sformatf("rr_ready1_%0d", c), req1_ready, (c % 2) == 1);
            checkVal($sformatf("rr_addr_%0d", c), mem_readAddress, ((c % 2) == 0) ? 8'(8'h20 + c) : 8'(8'h40 + c));
            if (c > 0) begin
                checkVal($sformatf("rr_rsp0v_%0d", c), rsp0_valid, ((c - 1) % 2) == 0);
                checkVal($sformatf("rr_rsp1v_%0d", c), rsp1_valid, ((c - 1) % 2) == 1);
                if (((c - 1) % 2) == 0)
                    checkVal($sformatf("rr_rsp0d_%0d", c), rsp0_data, initWord(8'(8'h20 + c - 1)));
                else
                    checkVal($sformatf("rr_rsp1d_%0d", c), rsp1_data, initWord(8'(8'h40 + c - 1)));
            end
            @(posedge clock); #2;
        end
        idleAll();
        @(negedge clock);
        checkVal("rr_lastRsp", {rsp0_valid, rsp1_valid}, 2'b01);
        checkVal("rr_lastData", rsp1_data, initWord(8'h45));

        // Lock held by port 1 across a write, an idle cycle and an unlocking read
        @(posedge clock); #2;
        doReset();
        setReq1(1, 1, 1, 8'h10, 32'h1);
        @(negedge clock);
        checkVal("lk_wrReady1", req1_ready, 1);
        checkVal("lk_wrEn", mem_writeEnable, 1);
        checkVal("lk_wrAddr", mem_writeAddress, 8'h10);
        checkVal("lk_wrData", mem_writeData, 32'h1);
        checkVal("lk_wrRdEn", mem_readEnable, 0);
        @(posedge clock); #2;
        setReq1(0, 0, 0, 8'h00, 32'h0);
        setReq0(1, 0, 0, 8'h11, 32'h0);
        @(negedge clock);
        checkVal("lk_holdReady0", req0_ready, 0);
        checkVal("lk_wrRspValid", rsp1_valid, 1);
        checkVal("lk_wrRspData", rsp1_data, 0);
        @(posedge clock); #2;
        setReq1(1, 0, 0, 8'h10, 32'h0);
        @(negedge clock);
        checkVal("lk_rdReady0", req0_ready, 0);
        checkVal("lk_rdReady1", req1_ready, 1);
        checkVal("lk_rdAddr", mem_readAddress, 8'h10);
        @(posedge clock); #2;
        setReq1(0, 0, 0, 8'h00, 32'h0);
        @(negedge clock);
        checkVal("lk_rspValid", rsp1_valid, 1);
        checkVal("lk_rspData", rsp1_data, 32'h1);
        checkVal("lk_unlockReady0", req0_ready, 1);

        // Forced release after LOCK_MAX=4 cycles
        @(posedge clock); #2;
        doReset();
        setReq0(1, 0, 1, 8'h05, 32'h0);
        @(negedge clock);
        checkVal("to_lockReady0", req0_ready, 1);
        @(posedge clock); #2;
        setReq0(0, 0, 0, 8'h00, 32'h0);
        setReq1(1, 0, 0, 8'h33, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            checkVal($sformatf("to_heldReady1_%0d", k), req1_ready, 0);
            checkVal($sformatf("to_heldPulse_%0d", k), lock_timeout, 0);
            @(posedge clock); #2;
        end
        @(negedge clock);
        checkVal("to_pulse", lock_timeout, 1);
        checkVal("to_noGrant", {req0_ready, req1_ready}, 0);
        checkVal("to_noRdEn", mem_readEnable, 0);
        @(posedge clock); #2;
        @(negedge clock);
        checkVal("to_pulseEnd", lock_timeout, 0);
        checkVal("to_ready1", req1_ready, 1);
        @(posedge clock); #2;
        setReq1(0, 0, 0, 8'h00, 32'h0);
        @(negedge clock);
        checkVal("to_rsp1Valid", rsp1_valid, 1);
        checkVal("to_rsp1Data", rsp1_data, initWord(8'h33));

        // Reset asserted the cycle after a grant discards the pending response
        @(posedge clock); #2;
        doReset();
        setReq0(1, 0, 0, 8'h05, 32'h0);
        @(negedge clock);
        checkVal("mr_grant0", req0_ready, 1);
        @(posedge clock); #2;
        reset = 1'b0;
        setReq1(1, 0, 0, 8'h09, 32'h0);
        #1;
        checkVal("mr_rsp0Valid", rsp0_valid, 0);
        checkVal("mr_rsp0Data", rsp0_data, 0);
        checkVal("mr_ready", {req0_ready, req1_ready}, 0);
        checkVal("mr_rdEn", mem_readEnable, 0);
        checkVal("mr_rdAddr", mem_readAddress, 0);
        @(negedge clock);
        checkVal("mr_rsp1Valid", rsp1_valid, 0);
        @(posedge clock); #2;
        reset = 1'b1;
        @(negedge clock);
        checkVal("mr_relReady0", req0_ready, 1);
        checkVal("mr_relReady1", req1_ready, 0);
        checkVal("mr_relRsp", {rsp0_valid, rsp1_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
